// File: rtl/seg_scan_driver_pkg.sv
// Shared types and glyph constants for the 4-digit seven-segment scanner.
// Glyphs are [0:6] = a..g, active-low.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  localparam logic [0:6] SEG_OFF = 7'b1111111;

  localparam logic [0:6] GLYPH_0 = 7'b0000001;
  localparam logic [0:6] GLYPH_1 = 7'b1001111;
  localparam logic [0:6] GLYPH_2 = 7'b0010010;
  localparam logic [0:6] GLYPH_3 = 7'b0000110;
  localparam logic [0:6] GLYPH_4 = 7'b1001100;
  localparam logic [0:6] GLYPH_5 = 7'b0100100;
  localparam logic [0:6] GLYPH_6 = 7'b0100000;
  localparam logic [0:6] GLYPH_7 = 7'b0001111;
  localparam logic [0:6] GLYPH_8 = 7'b0000000;
  localparam logic [0:6] GLYPH_9 = 7'b0000100;
  localparam logic [0:6] GLYPH_A = 7'b0001000;
  localparam logic [0:6] GLYPH_B = 7'b1100000;
  localparam logic [0:6] GLYPH_C = 7'b0110001;
  localparam logic [0:6] GLYPH_D = 7'b1000010;
  localparam logic [0:6] GLYPH_E = 7'b0110000;
  localparam logic [0:6] GLYPH_F = 7'b0111000;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display bus: scan control and digit data in, LED drive out.
// master = data source / observer, slave = scanner.
interface seg_scan_driver_if;

  logic        en;
  logic [15:0] digits_i;
  logic [3:0]  dp_i;
  logic [0:6]  seg;
  logic        dp;
  logic [3:0]  digit;
  logic        frame_tick;

  modport master (
    output en, digits_i, dp_i,
    input  seg, dp, digit, frame_tick
  );

  modport slave (
    input  en, digits_i, dp_i,
    output seg, dp, digit, frame_tick
  );

endinterface

// File: rtl/seg_scan_driver_decode.sv
// Hex nibble to active-low seven-segment glyph (purely combinational).
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [0:6] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    unique case (val_i)
      4'h0: seg_o = GLYPH_0;
      4'h1: seg_o = GLYPH_1;
      4'h2: seg_o = GLYPH_2;
      4'h3: seg_o = GLYPH_3;
      4'h4: seg_o = GLYPH_4;
      4'h5: seg_o = GLYPH_5;
      4'h6: seg_o = GLYPH_6;
      4'h7: seg_o = GLYPH_7;
      4'h8: seg_o = GLYPH_8;
      4'h9: seg_o = GLYPH_9;
      4'hA: seg_o = GLYPH_A;
      4'hB: seg_o = GLYPH_B;
      4'hC: seg_o = GLYPH_C;
      4'hD: seg_o = GLYPH_D;
      4'hE: seg_o = GLYPH_E;
      4'hF: seg_o = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit seven-segment scanner with dead time between digits.
// Optional leading-zero blanking via SEG_SCAN_LZB_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_driver_if.slave  bus
);

  localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ?
                        REFRESH_DIV : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [19:0]   shadow_q, shadow_d;
  logic [0:6]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    digit_q, digit_d;
  logic          tick_q, tick_d;

  logic [3:0]    nib;
  logic [3:0]    sdp;
  logic [0:6]    glyph;
  logic          blank_dig;

  assign nib = shadow_q[{idx_q, 2'b00} +: 4];
  assign sdp = shadow_q[19:16];

  seg7_decode u_dec (
    .val_i (nib),
    .seg_o (glyph)
  );

`ifdef SEG_SCAN_LZB_EN
  logic [3:0] lz;

  // A digit is a leading zero when it and every higher digit are zero
  always_comb begin
    lz    = 4'b0000;
    lz[3] = (shadow_q[15:12] == 4'h0);
    lz[2] = lz[3] && (shadow_q[11:8] == 4'h0);
    lz[1] = lz[2] && (shadow_q[7:4] == 4'h0);
  end

  assign blank_dig = lz[idx_q];
`else
  assign blank_dig = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + 1'b1;
    shadow_d = shadow_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.en) begin
          state_d = ST_BLANK;
          idx_d   = 2'd0;
        end
      end
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
          if (idx_q == 2'd0)
            shadow_d = {bus.dp_i, bus.digits_i};
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Disable wins over everything but keeps the last snapshot
    if (!bus.en) begin
      state_d  = ST_IDLE;
      idx_d    = 2'd0;
      cnt_d    = '0;
      shadow_d = shadow_q;
    end
  end

  always_comb begin
    seg_d   = SEG_OFF;
    dp_d    = 1'b1;
    digit_d = 4'b1111;
    tick_d  = 1'b0;
    if (bus.en && state_q == ST_SHOW) begin
      dp_d   = ~sdp[idx_q];
      tick_d = (idx_q == 2'd0) && (cnt_q == '0);
      if (!blank_dig) begin
        seg_d   = glyph;
        digit_d = ~(4'b0001 << idx_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      shadow_q <= '0;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
      digit_q  <= 4'b1111;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      digit_q  <= digit_d;
      tick_q   <= tick_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.digit      = digit_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed + random bench for seg_scan_driver against a frame-position model.
// Honours SEG_SCAN_LZB_EN the same way the design does.
module tb_seg_scan_driver;

  localparam int R = 4;
  localparam int B = 2;
  localparam int S = R + B;
  localparam int P = 4 * S;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seg_scan_driver_if bus ();

  seg_scan_driver #(
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lit segments of each hex glyph, by letter
  string lit [16] = '{
    "abcdef", "bc", "abdeg", "abcdg",
    "bcfg", "acdfg", "acdefg", "abc",
    "abcdefg", "abcdfg", "abcefg", "cdefg",
    "adef", "bcdeg", "adefg", "aefg"
  };

  // Model: running flag, position in frame, snapshot
  bit          m_run;
  int          m_pos;
  logic [19:0] m_snap;

  logic [6:0] e_seg;
  logic       e_dp;
  logic [3:0] e_digit;
  logic       e_tick;

  function automatic logic [6:0] glyph(int v);
    logic [6:0] r;
    string      s;
    r = 7'h7F;
    s = lit[v];
    for (int i = 0; i < s.len(); i++)
      r[6 - (s[i] - 8'h61)] = 1'b0;
    return r;
  endfunction

  task automatic model_edge();
    int  slot;
    int  w;
    int  val;
    bit  blank;
    e_seg   = 7'h7F;
    e_dp    = 1'b1;
    e_digit = 4'hF;
    e_tick  = 1'b0;
    if (rst_n && bus.en && m_run) begin
      slot = m_pos / S;
      w    = m_pos % S;
      if (w >= B) begin
        val   = int'((m_snap[15:0] >> (4 * slot)) & 16'hF);
        blank = 1'b0;
`ifdef SEG_SCAN_LZB_EN
        blank = (slot > 0) && ((m_snap[15:0] >> (4 * slot)) == 16'h0);
`endif
        e_dp   = ~m_snap[16 + slot];
        e_tick = (slot == 0) && (w == B);
        if (!blank) begin
          e_seg   = glyph(val);
          e_digit = ~(4'b0001 << slot);
        end
      end
    end
    if (!rst_n) begin
      m_run  = 1'b0;
      m_pos  = 0;
      m_snap = '0;
    end else if (!bus.en) begin
      m_run = 1'b0;
      m_pos = 0;
    end else begin
      if (!m_run) begin
        m_run = 1'b1;
        m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % P;
      end
      if (m_pos == B)
        m_snap = {bus.dp_i, bus.digits_i};
    end
  endtask

  task automatic chk(string tag, logic [6:0] got, logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    logic [6:0] sv;
    @(posedge clk);
    model_edge();
    #1;
    sv = bus.seg;
    chk("seg", sv, e_seg);
    chk("dp", {6'd0, bus.dp}, {6'd0, e_dp});
    chk("digit", {3'd0, bus.digit}, {3'd0, e_digit});
    chk("frame_tick", {6'd0, bus.frame_tick}, {6'd0, e_tick});
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_pos(int p);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4 * P && !found; i++) begin
      step();
      found = m_run && (m_pos == p);
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL wait_pos observed=timeout expected=pos %0d", p);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    m_run       = 1'b0;
    m_pos       = 0;
    m_snap      = '0;
    rst_n       = 1'b0;
    bus.en      = 1'b0;
    bus.digits_i = 16'h0000;
    bus.dp_i    = 4'h0;

    // Reset held, then released with scanning disabled
    run(3);
    rst_n = 1'b1;
    run(6);

    // Basic scan of 4321, two full frames
    bus.digits_i = 16'h4321;
    bus.en = 1'b1;
    run(2 * P + 4);

    // Change data while digit 1 is on: no tearing
    wait_pos(9);
    bus.digits_i = 16'h8765;
    run(2 * P);

    // Hex glyphs and a single decimal point
    bus.digits_i = 16'hFA0B;
    bus.dp_i = 4'b0100;
    run(2 * P);

    // Drop enable while digit 2 is shown, then restart
    wait_pos(15);
    bus.en = 1'b0;
    run(4);
    bus.en = 1'b1;
    run(P + 6);

    // Leading zeros
    bus.digits_i = 16'h0050;
    bus.dp_i = 4'b1000;
    run(2 * P);
    bus.digits_i = 16'h0000;
    bus.dp_i = 4'b0000;
    run(2 * P);

    // Reset in the middle of a shown digit, then restart
    wait_pos(16);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run(3);
    bus.digits_i = 16'h9C0D;
    run(P + 4);

    // Reset in the middle of dead time
    wait_pos(7);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run(P + 4);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0)
        bus.digits_i = 16'($urandom);
      if ($urandom_range(0, 7) == 0)
        bus.dp_i = 4'($urandom);
      if ($urandom_range(0, 7) == 0)
        bus.digits_i[15:8] = 8'h00;
      if ($urandom_range(0, 59) == 0)
        bus.en = ~bus.en;
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1;
    bus.en = 1'b1;
    run(P);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles each digit is shown (SHOW dwell); legal range >= 2.
REQ-002 Parameter BLANK_CYCLES, default 16, clk cycles of all-off dead time between digits; legal range >= 1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 en  input  1  scan enable; low = display dark.
REQ-006 digits_i  input  16  four 4-bit values; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-007 dp_i  input  4  decimal point request per digit, active-high, bit n = digit n.
REQ-008 seg  output  [0:6]  segments a..g (seg[0]=a), active-low, registered.
REQ-009 dp  output  1  decimal point, active-low, registered.
REQ-010 digit  output  4  anode select, active-low one-hot or all-ones, registered.
REQ-011 frame_tick  output  1  one-cycle pulse at the start of each scan frame.

Function
REQ-012 The FSM has states IDLE, BLANK and SHOW, plus a 2-bit index (0..3) and a prescaler counter.
REQ-013 IDLE: seg=7'b1111111, dp=1, digit=4'b1111; en=1 moves the FSM to BLANK with index=0.
REQ-014 BLANK: all outputs off for exactly BLANK_CYCLES cycles, then SHOW.
REQ-015 SHOW: digit[index]=0, others 1; seg/dp driven from shadow value of index; lasts exactly REFRESH_DIV cycles, then BLANK with index+1 (3 wraps to 0).
REQ-016 Entering SHOW with index=0, the block captures digits_i/dp_i into a 20-bit shadow register and pulses frame_tick for that one cycle; no tearing within a frame.
REQ-017 Decode: 0-9 as decimal glyphs, 10-15 as A,b,C,d,E,F; seg outputs are registered one cycle after state/index.
REQ-018 Full frame period = 4*(REFRESH_DIV+BLANK_CYCLES) cycles.
REQ-019 en falling in any state: next cycle state=IDLE, outputs off, prescaler=0, index=0; shadow retained.
REQ-020 en rising: frame restarts from BLANK/index 0; a new snapshot is taken at SHOW entry.
REQ-021 Prescaler width = $clog2(max(REFRESH_DIV,BLANK_CYCLES)); it clears on every state transition.

Reset
REQ-022 rst_n=0 at a clk edge: state=IDLE, index=0, prescaler=0, shadow=0, seg=7'b1111111, dp=1, digit=4'b1111, frame_tick=0.
REQ-023 Reset mid-SHOW or mid-BLANK takes effect at that edge; release followed by en=1 restarts cleanly at digit 0.

Configuration
REQ-024 Macro SEG_SCAN_LZB_EN defined: in SHOW, digit n (n=3..1) with shadow value 0 and all higher shadow values 0 keeps digit=4'b1111 and seg off (dp still honoured); digit 0 is never blanked.
REQ-025 Macro SEG_SCAN_LZB_EN undefined: every digit is always shown; no blanking logic is compiled.

Structure
REQ-026 Shared package seg_pkg holds the state enum, the 7-bit segment glyph constants for 0-F, and SEG_OFF=7'b1111111.
REQ-027 A combinational sub-module seg7_decode (4-bit in, [0:6] active-low out) is instantiated once.

Verification (REFRESH_DIV=4, BLANK_CYCLES=2)
REQ-028 Reset held, then released with en=0 -> seg=7'h7F, digit=4'b1111, frame_tick=0 on every cycle.
REQ-029 digits_i=16'h4321, en=1 -> digit 4'b1110/seg "1" for 4 cycles, 2 dark cycles, 4'b1101/"2", ... 4'b0111/"4"; frame_tick every 24 cycles.
REQ-030 digits_i changes 16'h4321->16'h8765 while showing digit 1 -> digits 2 and 3 show "3" and "4", the next frame shows 5,6,7,8.
REQ-031 digits_i=16'hFA0B, dp_i=4'b0100 -> glyphs b,0,A,F; dp=0 only while digit=4'b1011.
REQ-032 en dropped during SHOW of digit 2 -> next cycle all dark, IDLE; re-raise -> 2 dark cycles, then digit 0 with frame_tick.
REQ-033 With SEG_SCAN_LZB_EN, digits_i=16'h0050 -> digits 3 and 2 dark, digit 1 shows "5", digit 0 shows "0"; without the macro -> "0050".
